uart_tx_engine: RTL and testbench
=================================

// Module: uart_tx_engine
// PURPOSE
//  Serial transmit engine for the 16550-compatible UART; the consumer end of the transmit FIFO.
//  Pops one character at a time from the FIFO and serialises it onto the TX pad.
//  Frame order: start bit, 5-8 data bits LSB first, optional parity, 1/1.5/2 stop bits.
//  Bit timing comes from the shared 16x baud enable strobe.
// PARAMETERS
//  FIFO_WIDTH      8   width of tf_data_in (data bits per FIFO entry)
//  FIFO_COUNTER_W  5   width of tf_count (depth 16 -> 0..16)
// PORTS
//  clk          in   1               system clock
//  wb_rst_i     in   1               asynchronous, active-high reset
//  enable       in   1               16x baud strobe, one clk wide, 16 per bit time
//  lcr          in   8               [1:0] word len-5, [2] stop, [3] PEN, [4] EPS, [5] stick, [6] break
//  tf_data_in   in   FIFO_WIDTH      FIFO head entry; valid whenever tf_count != 0
//  tf_count     in   FIFO_COUNTER_W  FIFO occupancy
//  tf_pop       out  1               one-clk pop strobe to the FIFO
//  stx_pad_o    out  1               serial TX line, idle high
//  tstate       out  3               FSM state, for debug/status
//  tx_busy      out  1               high from pop until end of last stop bit
// BEHAVIOUR
//  Reset (async): state=IDLE, stx_pad_o=1, tf_pop=0, tx_busy=0, tick counter=0, shift reg=0.
//  Reset mid-frame aborts the frame immediately; the line returns high with no partial stop bit.
//  All state advances happen only on clk edges with enable=1, except the pop cycle (below).
//  States: IDLE(0) POP(1) START(2) DATA(3) PARITY(4) STOP(5).
//  IDLE: line 1. If tf_count!=0 on an enable clk: go to POP.
//  POP: tf_pop=1 for exactly one clk (not gated by enable).
//   - tf_data_in is loaded into the shift reg on the same edge.
//   - lcr[5:0] is latched into a frame config reg. lcr changes mid-frame affect only the next frame.
//   - Next state START; tick counter cleared.
//  START: line 0 for 16 enables, then DATA.
//  DATA: shift out LSB first, 16 enables per bit, word length = cfg[1:0]+5.
//   After the last bit: PARITY if cfg[3], else STOP.
//  PARITY: 16 enables. Bit value = data bits beyond the word length excluded; then:
//   - cfg[5]=1 (stick): bit = ~cfg[4]
//   - cfg[4]=1: bit = ^data (even parity)
//   - else: bit = ~^data (odd parity)
//  STOP: line 1. Length:
//   - 16 enables if cfg[2]=0
//   - 24 enables if cfg[2]=1 and 5-bit words
//   - 32 enables otherwise
//   Then: if tf_count!=0, go directly to POP (back-to-back frames, no idle gap); else IDLE.
//  Break: stx_pad_o = lcr[6] ? 0 : serial_bit. Uses live lcr, not latched; FSM keeps running.
//  tstate reflects the encoded state. tx_busy=1 in every state except IDLE.
//  Empty FIFO (tf_count==0) never pops; a pop at count 0 is a design error (assertion).
//  enable held high continuously is legal: 1 bit = 16 clks.
//  Tick counter: 5 bits, wraps to 0 at each bit/stop boundary.
// TESTING
//  1. lcr=0x03, FIFO holds 0x55, enable every clk.
//     -> 1 pop; line: 0, 1,0,1,0,1,0,1,0, 1; each bit 16 clks; tx_busy falls after 160 clks.
//  2. lcr=0x1B (8E1), data 0x07 -> parity bit 1; lcr=0x0B (8O1), data 0x07 -> parity bit 0;
//     lcr=0x3B -> 0; lcr=0x2B -> 1.
//  3. lcr=0x04 (5N1.5), data 0x1F -> 5 data bits; stop lasts 24 enables.
//     lcr=0x07 -> stop lasts 32 enables.
//  4. 3 entries queued, lcr=0x03 -> 3 pops; stop of frame n is followed by start of n+1
//     with no idle enable between.
//  5. Assert lcr[6] mid-DATA -> stx_pad_o=0 that clk; deassert -> frame resumes at the correct bit.
//     Change lcr[1:0] mid-frame -> current frame length unchanged.
//  6. wb_rst_i pulsed mid-DATA -> stx_pad_o=1, tx_busy=0, tstate=0 before the next clk edge;
//     no extra pop after release.

Source files
------------

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops characters from the TX FIFO and serialises them
// as start / 5-8 data bits (LSB first) / optional parity / 1, 1.5 or 2 stop bits.
module uart_tx_engine #(
    parameter int FIFO_WIDTH     = 8,
    parameter int FIFO_COUNTER_W = 5
) (
    input  logic                      clk,
    input  logic                      wb_rst_i,
    input  logic                      enable,
    input  logic [7:0]                lcr,
    input  logic [FIFO_WIDTH-1:0]     tf_data_in,
    input  logic [FIFO_COUNTER_W-1:0] tf_count,
    output logic                      tf_pop,
    output logic                      stx_pad_o,
    output logic [2:0]                tstate,
    output logic                      tx_busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP    = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t                state, state_nxt;
    logic [4:0]            tick, tick_nxt;
    logic [FIFO_WIDTH-1:0] shift_reg, shift_nxt;
    logic [2:0]            bit_cnt, bit_cnt_nxt;
    logic [5:0]            cfg, cfg_nxt;
    logic                  par_bit, par_nxt;
    logic                  serial_bit;
    logic [2:0]            last_bit;
    logic                  lcr_unused;

    // Parity over the configured word length only; bits above it are ignored.
    function automatic logic parity_bit(input logic [FIFO_WIDTH-1:0] data,
                                        input logic [5:0] c);
        logic [FIFO_WIDTH-1:0] masked;
        masked = '0;
        for (int i = 0; i < FIFO_WIDTH; i++)
            if (i < int'(c[1:0]) + 5) masked[i] = data[i];
        if (c[5])      return ~c[4];
        else if (c[4]) return ^masked;
        else           return ~^masked;
    endfunction

    function automatic logic [4:0] stop_last_tick(input logic [5:0] c);
        if (!c[2])            return 5'd15;
        else if (c[1:0] == 0) return 5'd23;
        else                  return 5'd31;
    endfunction

    assign last_bit   = {1'b0, cfg[1:0]} + 3'd4;
    assign lcr_unused = lcr[7];

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            tick      <= '0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            cfg       <= '0;
            par_bit   <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick      <= tick_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            cfg       <= cfg_nxt;
            par_bit   <= par_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tick_nxt    = tick;
        shift_nxt   = shift_reg;
        bit_cnt_nxt = bit_cnt;
        cfg_nxt     = cfg;
        par_nxt     = par_bit;
        tf_pop      = 1'b0;
        serial_bit  = 1'b1;
        case (state)
            S_IDLE: begin
                if (enable && tf_count != '0) state_nxt = S_POP;
            end
            // The pop cycle is not gated by enable: it always lasts one clk.
            S_POP: begin
                tf_pop      = 1'b1;
                shift_nxt   = tf_data_in;
                cfg_nxt     = lcr[5:0];
                par_nxt     = parity_bit(tf_data_in, lcr[5:0]);
                tick_nxt    = '0;
                bit_cnt_nxt = '0;
                state_nxt   = S_START;
            end
            S_START: begin
                serial_bit = 1'b0;
                if (enable) begin
                    if (tick == 5'd15) begin
                        tick_nxt  = '0;
                        state_nxt = S_DATA;
                    end else begin
                        tick_nxt = tick + 5'd1;
                    end
                end
            end
            S_DATA: begin
                serial_bit = shift_reg[0];
                if (enable) begin
                    if (tick == 5'd15) begin
                        tick_nxt    = '0;
                        shift_nxt   = shift_reg >> 1;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == last_bit)
                            state_nxt = cfg[3] ? S_PARITY : S_STOP;
                    end else begin
                        tick_nxt = tick + 5'd1;
                    end
                end
            end
            S_PARITY: begin
                serial_bit = par_bit;
                if (enable) begin
                    if (tick == 5'd15) begin
                        tick_nxt  = '0;
                        state_nxt = S_STOP;
                    end else begin
                        tick_nxt = tick + 5'd1;
                    end
                end
            end
            S_STOP: begin
                if (enable) begin
                    if (tick == stop_last_tick(cfg)) begin
                        tick_nxt  = '0;
                        state_nxt = (tf_count != '0) ? S_POP : S_IDLE;
                    end else begin
                        tick_nxt = tick + 5'd1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Break uses the live lcr so it takes effect immediately, independent of the frame.
    assign stx_pad_o = lcr[6] ? 1'b0 : serial_bit;
    assign tstate    = state;
    assign tx_busy   = (state != S_IDLE);

    assert property (@(posedge clk) disable iff (wb_rst_i) tf_pop |-> (tf_count != '0));

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: a small FIFO model feeds frames and every
// serial bit, stop length and status output is compared to hand-derived values.
module tb_uart_tx_engine;

    logic       clk = 1'b0;
    logic       wb_rst_i;
    logic       enable;
    logic [7:0] lcr;
    logic [7:0] tf_data_in;
    logic [4:0] tf_count;
    logic       tf_pop;
    logic       stx_pad_o;
    logic [2:0] tstate;
    logic       tx_busy;

    logic [7:0] mem [16];
    logic [7:0] wr_ptr = '0;
    logic [7:0] rd_ptr = '0;
    int         pop_cnt = 0;
    int         n_total = 0;
    int         n_bad = 0;
    int         frame_clk;

    uart_tx_engine #(.FIFO_WIDTH(8), .FIFO_COUNTER_W(5)) dut (
        .clk        (clk),
        .wb_rst_i   (wb_rst_i),
        .enable     (enable),
        .lcr        (lcr),
        .tf_data_in (tf_data_in),
        .tf_count   (tf_count),
        .tf_pop     (tf_pop),
        .stx_pad_o  (stx_pad_o),
        .tstate     (tstate),
        .tx_busy    (tx_busy)
    );

    always #5 clk = ~clk;

    assign tf_count   = 5'(wr_ptr - rd_ptr);
    assign tf_data_in = mem[rd_ptr[3:0]];

    always @(posedge clk) begin
        if (tf_pop) begin
            rd_ptr  <= rd_ptr + 8'd1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[3:0]] = d;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    // Line must hold exp for a full 16-clk bit time (enable every clk).
    task automatic bit_ok(input string tag, input logic exp);
        logic good;
        good = 1'b1;
        repeat (16) begin
            if (stx_pad_o !== exp) good = 1'b0;
            @(negedge clk);
            frame_clk++;
        end
        chk(tag, {31'd0, good}, 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] data, input int nbits,
                               input bit has_par, input logic par, input int stop_len);
        int  k;
        logic hi;
        k = 0;
        while (stx_pad_o !== 1'b0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_start_seen"}, {31'd0, k < 400}, 32'd1);
        frame_clk = 0;
        bit_ok({tag, "_start"}, 1'b0);
        for (int i = 0; i < nbits; i++)
            bit_ok($sformatf("%s_d%0d", tag, i), data[i]);
        if (has_par) bit_ok({tag, "_par"}, par);
        k  = 0;
        hi = 1'b1;
        while (tstate == 3'd5 && k < 64) begin
            if (stx_pad_o !== 1'b1) hi = 1'b0;
            @(negedge clk);
            k++;
            frame_clk++;
        end
        chk({tag, "_stop_len"}, k, stop_len);
        chk({tag, "_stop_high"}, {31'd0, hi}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        wb_rst_i = 1'b1;
        enable   = 1'b1;
        lcr      = 8'h03;
        #1;
        chk("rst_line", {31'd0, stx_pad_o}, 32'd1);
        chk("rst_pop", {31'd0, tf_pop}, 32'd0);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_state", {29'd0, tstate}, 32'd0);
        repeat (3) @(negedge clk);
        wb_rst_i = 1'b0;

        // Gating: data queued but no enable -> nothing happens.
        enable = 1'b0;
        push(8'h55);
        repeat (6) @(negedge clk);
        chk("gate_state", {29'd0, tstate}, 32'd0);
        chk("gate_pops", pop_cnt, 0);
        enable = 1'b1;

        // 8N1 0x55
        check_frame("t1", 8'h55, 8, 1'b0, 1'b0, 16);
        chk("t1_frame_clks", frame_clk, 160);
        chk("t1_busy_end", {31'd0, tx_busy}, 32'd0);
        chk("t1_pops", pop_cnt, 1);

        // Parity variants on 0x07
        lcr = 8'h1B; push(8'h07); check_frame("t2_even", 8'h07, 8, 1'b1, 1'b1, 16);
        lcr = 8'h0B; push(8'h07); check_frame("t2_odd", 8'h07, 8, 1'b1, 1'b0, 16);
        lcr = 8'h3B; push(8'h07); check_frame("t2_stk0", 8'h07, 8, 1'b1, 1'b0, 16);
        lcr = 8'h2B; push(8'h07); check_frame("t2_stk1", 8'h07, 8, 1'b1, 1'b1, 16);

        // Stop lengths
        lcr = 8'h04; push(8'h1F); check_frame("t3_5n15", 8'h1F, 5, 1'b0, 1'b0, 24);
        lcr = 8'h07; push(8'hA5); check_frame("t3_8n2", 8'hA5, 8, 1'b0, 1'b0, 32);

        // Back-to-back frames
        lcr = 8'h03;
        p   = pop_cnt;
        push(8'h31); push(8'h32); push(8'h33);
        check_frame("t4_f0", 8'h31, 8, 1'b0, 1'b0, 16);
        chk("t4_b2b0", {29'd0, tstate}, 32'd1);
        check_frame("t4_f1", 8'h32, 8, 1'b0, 1'b0, 16);
        chk("t4_b2b1", {29'd0, tstate}, 32'd1);
        check_frame("t4_f2", 8'h33, 8, 1'b0, 1'b0, 16);
        chk("t4_idle", {29'd0, tstate}, 32'd0);
        chk("t4_pops", pop_cnt - p, 3);

        // Break mid-DATA plus a word-length change that must not affect this frame
        lcr = 8'h03;
        push(8'h50);
        begin
            int k;
            k = 0;
            while (stx_pad_o !== 1'b0 && k < 400) begin
                @(negedge clk);
                k++;
            end
            chk("t5_start_seen", {31'd0, k < 400}, 32'd1);
        end
        repeat (88) @(negedge clk);
        lcr = 8'h40;
        #1;
        chk("t5_break_on", {31'd0, stx_pad_o}, 32'd0);
        repeat (4) @(negedge clk);
        chk("t5_fsm_runs", {29'd0, tstate}, 32'd3);
        lcr = 8'h00;
        #1;
        chk("t5_resume_d4", {31'd0, stx_pad_o}, 32'd1);
        repeat (4) @(negedge clk);
        bit_ok("t5_d5", 1'b0);
        bit_ok("t5_d6", 1'b1);
        bit_ok("t5_d7", 1'b0);
        chk("t5_in_stop", {29'd0, tstate}, 32'd5);
        begin
            int k;
            k = 0;
            while (tstate == 3'd5 && k < 64) begin
                @(negedge clk);
                k++;
            end
            chk("t5_stop_len", k, 16);
        end

        // Reset mid-DATA
        lcr = 8'h03;
        push(8'h55);
        begin
            int k;
            k = 0;
            while (stx_pad_o !== 1'b0 && k < 400) begin
                @(negedge clk);
                k++;
            end
            chk("t6_start_seen", {31'd0, k < 400}, 32'd1);
        end
        repeat (40) @(negedge clk);
        chk("t6_pre_state", {29'd0, tstate}, 32'd3);
        #1 wb_rst_i = 1'b1;
        #1;
        chk("t6_line", {31'd0, stx_pad_o}, 32'd1);
        chk("t6_busy", {31'd0, tx_busy}, 32'd0);
        chk("t6_state", {29'd0, tstate}, 32'd0);
        wr_ptr = rd_ptr;
        @(negedge clk);
        wb_rst_i = 1'b0;
        p = pop_cnt;
        repeat (40) @(negedge clk);
        chk("t6_no_pop", pop_cnt - p, 0);
        chk("t6_idle", {29'd0, tstate}, 32'd0);
        chk("t6_idle_line", {31'd0, stx_pad_o}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
